// File: rtl/i2c_write_master.sv
// I2C write master: START, up to NBYTES_MAX bytes with ACK checks, then STOP,
// driven in lockstep on any subset of NLINES SCL/SDA pairs.

// Per-line output gate: an unselected line is held released (high).
module i2c_lane_gate (
  input  logic sel,
  input  logic scl_pat,
  input  logic sda_pat,
  output logic scl_out,
  output logic sda_out
);
  assign scl_out = sel ? scl_pat : 1'b1;
  assign sda_out = sel ? sda_pat : 1'b1;
endmodule

module i2c_write_master #(
  parameter int NBYTES_MAX = 4,
  parameter int NLINES     = 2,
  parameter int QTR_DIV    = 32768,
  localparam int BW        = (NBYTES_MAX > 1) ? $clog2(NBYTES_MAX) : 1,
  localparam int NW        = BW + 1,
  localparam int DBW       = 8 * NBYTES_MAX
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [NLINES-1:0] LINE_SEL,
  input  logic [NW-1:0]     NBYTES,
  input  logic [DBW-1:0]    DATA,
  input  logic [NLINES-1:0] SDA_IN,
  output logic [NLINES-1:0] SCL_OUT,
  output logic [NLINES-1:0] SDA_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              NACK,
  output logic [BW-1:0]     NACK_BYTE
);

  localparam int DW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  typedef enum logic [2:0] {IDLE, STRT, BIT, ACK, STOP} state_t;

  state_t                   state, state_n;
  logic                     start_r, start_d;
  logic [1:0][NLINES-1:0]   sda_sync;
  logic [DBW-1:0]           data_q;
  logic [NW-1:0]            nbytes_q;
  logic [NLINES-1:0]        lsel_q;
  logic [DW-1:0]            div_cnt;
  logic [1:0]               qtr;
  logic [2:0]               bit_cnt;
  logic [BW-1:0]            byte_cnt;
  logic                     nack_smp;
  logic                     done_q, nack_q;
  logic [BW-1:0]            nack_byte_q;

  logic                     start_edge, accept, qtr_end, phase_end, last_byte;
  logic [NW-1:0]            nb_clamp;
  logic                     scl_pat, sda_pat;

  assign start_edge = start_r & ~start_d;
  assign accept     = (state == IDLE) & start_edge;
  assign qtr_end    = (div_cnt == DW'(QTR_DIV - 1));
  assign phase_end  = qtr_end & (qtr == 2'd3);
  assign last_byte  = (({1'b0, byte_cnt} + NW'(1)) == nbytes_q);
  assign nb_clamp   = (NBYTES > NW'(NBYTES_MAX)) ? NW'(NBYTES_MAX) : NBYTES;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: phases advance only at the end of a quarter-3.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept && (LINE_SEL != '0)) state_n = STRT;
      STRT: if (phase_end) state_n = (nbytes_q == '0) ? STOP : BIT;
      BIT:  if (phase_end && (bit_cnt == 3'd7)) state_n = ACK;
      ACK:  if (phase_end) state_n = (nack_smp || last_byte) ? STOP : BIT;
      STOP: if (phase_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Quarter-bit waveform shared by every selected line; IDLE releases the bus.
  always_comb begin
    scl_pat = 1'b1;
    sda_pat = 1'b1;
    case (state)
      STRT: begin scl_pat = (qtr != 2'd3); sda_pat = ~qtr[1]; end
      BIT:  begin scl_pat = qtr[0] ^ qtr[1]; sda_pat = data_q[DBW-1]; end
      ACK:  begin scl_pat = qtr[0] ^ qtr[1]; end
      STOP: begin scl_pat = (qtr != 2'd0); sda_pat = qtr[1]; end
      default: ;
    endcase
  end

  // Datapath: edge detect, ACK synchroniser, divider, counters, status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_r     <= 1'b0;
      start_d     <= 1'b0;
      sda_sync    <= '1;
      data_q      <= '0;
      nbytes_q    <= '0;
      lsel_q      <= '0;
      div_cnt     <= '0;
      qtr         <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      nack_smp    <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      nack_byte_q <= '0;
    end else begin
      start_r  <= START;
      start_d  <= start_r;
      sda_sync <= {sda_sync[0], SDA_IN};
      done_q   <= 1'b0;
      if (accept) begin
        data_q      <= DATA;
        nbytes_q    <= nb_clamp;
        lsel_q      <= LINE_SEL;
        div_cnt     <= '0;
        qtr         <= '0;
        bit_cnt     <= '0;
        byte_cnt    <= '0;
        nack_smp    <= 1'b0;
        nack_byte_q <= '0;
        // No lines selected: nobody can ACK, finish immediately.
        nack_q      <= (LINE_SEL == '0);
        done_q      <= (LINE_SEL == '0);
      end else if (state != IDLE) begin
        div_cnt <= qtr_end ? '0 : div_cnt + DW'(1);
        if (qtr_end) qtr <= qtr + 2'd1;
        if ((state == BIT) && phase_end) begin
          data_q  <= {data_q[DBW-2:0], 1'b0};
          bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
        end
        // Sample on the last CLK of ACK quarter 2 (SCL high, data settled).
        if ((state == ACK) && (qtr == 2'd2) && qtr_end)
          nack_smp <= |(sda_sync[1] & lsel_q);
        if ((state == ACK) && phase_end) begin
          if (nack_smp) begin
            nack_q      <= 1'b1;
            nack_byte_q <= byte_cnt;
          end else if (!last_byte) begin
            byte_cnt <= byte_cnt + BW'(1);
          end
        end
        if ((state == STOP) && phase_end) done_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NLINES; i++) begin : g_lane
    i2c_lane_gate u_gate (
      .sel     (lsel_q[i]),
      .scl_pat (scl_pat),
      .sda_pat (sda_pat),
      .scl_out (SCL_OUT[i]),
      .sda_out (SDA_OUT[i])
    );
  end

  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;
  assign NACK      = nack_q;
  assign NACK_BYTE = nack_byte_q;

endmodule
